aes_encipher_block: RTL and testbench
=====================================

AES_ENCIPHER_BLOCK -- requirements
Module: aes_encipher_block

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port next  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port keylen  input  2  0=AES-128, 1=AES-192, 2=AES-256; sampled with next.
REQ-006 SHALL have port block  input  128  plaintext; sampled with next.
REQ-007 SHALL have port round  output  4  round-key index presented to the key memory.
REQ-008 SHALL have port round_key  input  128  key memory word for the current round; combinational response, same cycle.
REQ-009 SHALL have port sboxw  output  32  word sent to the shared S-box.
REQ-010 SHALL have port new_sboxw  input  32  S-box result for sboxw; combinational, same cycle.
REQ-011 SHALL have port ready  output  1  high when idle and result is valid.
REQ-012 SHALL have port result  output  128  ciphertext; held stable while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, INIT, SBOX, MAIN.
- IDLE: next=1 -> INIT, latch block, latch keylen, ready<=0.
- INIT: state=block^round_key at round=0, round_ctr<=1 -> SBOX.
- SBOX: 4 cycles, word_ctr 0..3; sboxw=state word word_ctr (word 0 = [127:96]); new_sboxw stored in the same word slot -> MAIN after word 3.
- MAIN: ShiftRows then MixColumns, XOR round_key at round=round_ctr, round_ctr++ -> SBOX.
- MAIN when round_ctr==Nr (final round): omit MixColumns, result<=value, ready<=1 -> IDLE.
REQ-014 SHALL use Nr=10/12/14 for keylen 0/1/2, taken from the latched keylen.
REQ-015 SHALL drive round=round_ctr in SBOX/MAIN, 0 in INIT and IDLE.
REQ-016 SHALL give fixed latency, next sampled at cycle 0: ready=1 at cycle 2+5*Nr (52/62/72).
REQ-017 SHALL ignore next while not IDLE; block/keylen changes mid-operation SHALL have no effect.
REQ-018 SHALL accept next in the same cycle ready is high, allowing back-to-back blocks; result is overwritten only at the final MAIN.
REQ-019 SHALL drive sboxw=0 outside SBOX.
REQ-020 SHALL map keylen=3 to Nr=14 unless REQ-024 applies.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, set state=IDLE, ready=1, result=0, round_ctr=0, word_ctr=0, internal state=0.
REQ-022 SHALL, on reset mid-operation, abort within one cycle with no partial result exposed.

Configuration
REQ-023 SHALL compile the keylen check in or out with the macro AES_ENC_KEYLEN_CHECK_EN.
REQ-024 SHALL, with AES_ENC_KEYLEN_CHECK_EN defined:
- add port keylen_err  output  1, reset 0.
- next with keylen=3 in IDLE: no start, ready stays 1, keylen_err pulses high for exactly one cycle.
REQ-025 SHALL, without AES_ENC_KEYLEN_CHECK_EN: no keylen_err port, REQ-020 applies.

Structure
REQ-026 SHALL place keylen encodings, Nr constants and FSM state encodings in shared package aes_pkg.
REQ-027 SHALL put ShiftRows+MixColumns (GF(2^8) xtime, poly 0x1b) in combinational sub-module aes_enc_round with a final-round bypass input.

Verification
REQ-028 SHALL cover AES-128: key 000102..0f, pt 00112233445566778899aabbccddeeff -> result 69c4e0d86a7b0430d8cdb78070b4c55a, ready at cycle 52.
REQ-029 SHALL cover AES-192: key 000102..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, ready at cycle 62.
REQ-030 SHALL cover AES-256: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, ready at cycle 72.
REQ-031 SHALL cover next pulsed at cycle 20 of a run, plus block changed mid-run -> ignored; result unchanged from REQ-028.
REQ-032 SHALL cover reset at cycle 30 -> next cycle ready=1, result=0, round=0; a fresh run then gives the REQ-028 value.
REQ-033 SHALL cover keylen=3 with macro defined -> keylen_err one-cycle pulse, no start; without macro -> AES-256 timing (72 cycles).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES encipher definitions: key-length encodings, round counts and FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'd0,
    KEYLEN_192  = 2'd1,
    KEYLEN_256  = 2'd2,
    KEYLEN_RSVD = 2'd3
  } keylen_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } enc_state_e;

  // The reserved encoding runs as AES-256 when it is allowed to start at all.
  function automatic logic [3:0] num_rounds(input keylen_e kl);
    case (kl)
      KEYLEN_128: return NR_128;
      KEYLEN_192: return NR_192;
      default:    return NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational ShiftRows followed by MixColumns; final_round bypasses MixColumns.
module aes_enc_round (
  input  logic [127:0] state_in,
  input  logic         final_round,
  output logic [127:0] state_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] shifted;

  // Byte 4*c+r is row r of column c; row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end

  always_comb begin
    state_out = shifted;
    if (!final_round) begin
      for (int c = 0; c < 4; c++) begin
        state_out[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher using an external key memory and a shared one-word S-box.
// Define AES_ENC_KEYLEN_CHECK_EN to reject keylen=3 with a one-cycle keylen_err pulse.
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [1:0]   keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic         ready,
  output logic [127:0] result
`ifdef AES_ENC_KEYLEN_CHECK_EN
  ,
  output logic         keylen_err
`endif
);

  enc_state_e   state_q, state_d;
  keylen_e      keylen_q, keylen_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic         ready_q, ready_d;
  logic [127:0] result_q, result_d;
  logic [127:0] round_out;
  logic         start;
  logic         final_round;

  assign final_round = (round_ctr_q == num_rounds(keylen_q));

  aes_enc_round u_round (
    .state_in    (blk_q),
    .final_round (final_round),
    .state_out   (round_out)
  );

`ifdef AES_ENC_KEYLEN_CHECK_EN
  logic keylen_err_q, keylen_err_d;

  assign start        = next && (keylen != KEYLEN_RSVD);
  assign keylen_err_d = (state_q == ST_IDLE) && next && (keylen == KEYLEN_RSVD);
  assign keylen_err   = keylen_err_q;

  always_ff @(posedge clk) begin
    if (reset) keylen_err_q <= 1'b0;
    else       keylen_err_q <= keylen_err_d;
  end
`else
  assign start = next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      keylen_q    <= KEYLEN_128;
      blk_q       <= '0;
      round_ctr_q <= '0;
      word_ctr_q  <= '0;
      ready_q     <= 1'b1;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      keylen_q    <= keylen_d;
      blk_q       <= blk_d;
      round_ctr_q <= round_ctr_d;
      word_ctr_q  <= word_ctr_d;
      ready_q     <= ready_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_INIT;
      ST_INIT: state_d = ST_SBOX;
      ST_SBOX: if (word_ctr_q == 2'd3) state_d = ST_MAIN;
      ST_MAIN: state_d = final_round ? ST_IDLE : ST_SBOX;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word 0 of the state is [127:96], so the slot base is the inverted word index.
  always_comb begin
    blk_d       = blk_q;
    keylen_d    = keylen_q;
    round_ctr_d = round_ctr_q;
    word_ctr_d  = word_ctr_q;
    ready_d     = ready_q;
    result_d    = result_q;
    round       = 4'd0;
    sboxw       = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          blk_d       = block;
          keylen_d    = keylen_e'(keylen);
          ready_d     = 1'b0;
          round_ctr_d = 4'd0;
          word_ctr_d  = 2'd0;
        end
      end
      ST_INIT: begin
        blk_d       = blk_q ^ round_key;
        round_ctr_d = 4'd1;
      end
      ST_SBOX: begin
        round                              = round_ctr_q;
        sboxw                              = blk_q[{~word_ctr_q, 5'd0} +: 32];
        blk_d[{~word_ctr_q, 5'd0} +: 32]   = new_sboxw;
        word_ctr_d                         = word_ctr_q + 2'd1;
      end
      ST_MAIN: begin
        round = round_ctr_q;
        blk_d = round_out ^ round_key;
        if (final_round) begin
          result_d = round_out ^ round_key;
          ready_d  = 1'b1;
        end else begin
          round_ctr_d = round_ctr_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed bench for aes_encipher_block with a behavioural key memory and S-box.
// Also covers the AES_ENC_KEYLEN_CHECK_EN build when that macro is defined.
module tb_aes_encipher_block;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam int           MAX_CYCLES = 200;

  logic         clk;
  logic         reset;
  logic         next;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;
  logic [127:0] result;
`ifdef AES_ENC_KEYLEN_CHECK_EN
  logic         keylen_err;
`endif

  logic [7:0]   sboxTab [256];
  logic [31:0]  w [60];
  logic [127:0] rk [16];
  int           cyc;
  int           testsRun;
  int           testsFailed;

  aes_encipher_block dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .keylen    (keylen),
    .block     (block),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .ready     (ready),
    .result    (result)
`ifdef AES_ENC_KEYLEN_CHECK_EN
    ,
    .keylen_err(keylen_err)
`endif
  );

  always #5 clk = ~clk;

  // Key memory and S-box answer combinationally, like the surrounding cipher core.
  assign round_key = rk[round];
  assign new_sboxw = {sboxTab[sboxw[31:24]], sboxTab[sboxw[23:16]],
                      sboxTab[sboxw[15:8]],  sboxTab[sboxw[7:0]]};

  function automatic logic [7:0] gfXtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gfXtime(x);
    end
    return p;
  endfunction

  // S-box built from its definition: multiplicative inverse then the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a   = 8'(i);
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gfMul(inv, a);
      end
      sboxTab[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] t);
    return {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
  endfunction

  // Standard key schedule for the sequential key 00 01 02 ... of nk words.
  task automatic expandKey(input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gfXtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) stepCycles(1);
  endtask

  // Pulses next for one cycle; afterwards the bench sits in cycle 1 (INIT).
  task automatic applyStimulus(input logic [1:0] kl, input logic [127:0] pt);
    expandKey((kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8,
              (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14);
    keylen = kl;
    block  = pt;
    next   = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    cyc  = 1;
  endtask

  task automatic waitReady();
    while (ready !== 1'b1 && cyc < MAX_CYCLES) stepCycles(1);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    clk         = 1'b0;
    reset       = 1'b1;
    next        = 1'b0;
    keylen      = 2'd0;
    block       = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    buildSbox();

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_ready", 128'(ready), 128'd1);
    checkOutput("reset_result", result, 128'd0);
    checkOutput("reset_round", 128'(round), 128'd0);
    checkOutput("reset_sboxw", 128'(sboxw), 128'd0);
`ifdef AES_ENC_KEYLEN_CHECK_EN
    checkOutput("reset_keylen_err", 128'(keylen_err), 128'd0);
`endif

    // AES-128 with a look at the INIT cycle and the first S-box word (pt ^ key word 0).
    applyStimulus(2'd0, PT);
    checkOutput("init_ready", 128'(ready), 128'd0);
    checkOutput("init_round", 128'(round), 128'd0);
    checkOutput("init_sboxw", 128'(sboxw), 128'd0);
    stepCycles(1);
    checkOutput("sbox0_round", 128'(round), 128'd1);
    checkOutput("sbox0_sboxw", 128'(sboxw), 128'h00102030);
    waitReady();
    checkOutput("aes128_latency", 128'(cyc), 128'd52);
    checkOutput("aes128_result", result, CT128);

    // Back-to-back AES-192 started in the cycle ready rose; old result held until done.
    applyStimulus(2'd1, PT);
    stepTo(30);
    checkOutput("b2b_ready_low", 128'(ready), 128'd0);
    checkOutput("b2b_result_held", result, CT128);
    waitReady();
    checkOutput("aes192_latency", 128'(cyc), 128'd62);
    checkOutput("aes192_result", result, CT192);

    applyStimulus(2'd2, PT);
    waitReady();
    checkOutput("aes256_latency", 128'(cyc), 128'd72);
    checkOutput("aes256_result", result, CT256);
    stepCycles(5);
    checkOutput("idle_ready_hold", 128'(ready), 128'd1);
    checkOutput("idle_result_hold", result, CT256);

    // next, keylen and block disturbed mid-run must not affect the AES-128 result.
    applyStimulus(2'd0, PT);
    stepTo(20);
    next   = 1'b1;
    keylen = 2'd2;
    block  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    stepCycles(1);
    next = 1'b0;
    waitReady();
    checkOutput("ignore_latency", 128'(cyc), 128'd52);
    checkOutput("ignore_result", result, CT128);

    // Synchronous reset in the middle of a run.
    applyStimulus(2'd0, PT);
    stepTo(30);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("midreset_ready", 128'(ready), 128'd1);
    checkOutput("midreset_result", result, 128'd0);
    checkOutput("midreset_round", 128'(round), 128'd0);
    applyStimulus(2'd0, PT);
    waitReady();
    checkOutput("postreset_latency", 128'(cyc), 128'd52);
    checkOutput("postreset_result", result, CT128);

`ifdef AES_ENC_KEYLEN_CHECK_EN
    keylen = 2'd3;
    next   = 1'b1;
    stepCycles(1);
    next = 1'b0;
    checkOutput("kl3_err_pulse", 128'(keylen_err), 128'd1);
    checkOutput("kl3_ready_stays", 128'(ready), 128'd1);
    stepCycles(1);
    checkOutput("kl3_err_clear", 128'(keylen_err), 128'd0);
    checkOutput("kl3_no_start_ready", 128'(ready), 128'd1);
    checkOutput("kl3_no_start_round", 128'(round), 128'd0);
    checkOutput("kl3_result_kept", result, CT128);
`else
    applyStimulus(2'd3, PT);
    waitReady();
    checkOutput("kl3_latency", 128'(cyc), 128'd72);
    checkOutput("kl3_result", result, CT256);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
